// File: rtl/alu_carry_pipe.sv
// Purpose : two-level carry-lookahead adder back end; turns per-bit g/p plus cin into sum, cout, ovf, zero.
// Latency : 2 cycles. Input captured at edge N+1 is visible on out_valid after edge N+2 (S1 group terms, S2 carries).
// Backpres: valid/ready on both sides; a stalled stage holds its data; out_ready -> in_ready is the only comb path.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   input handshake for g, p, cin
//   g, p [WIDTH]          per-bit generate / propagate (p doubles as the half sum a^b)
//   cin                   carry into bit 0
//   out_valid / out_ready output handshake for sum, cout, ovf, zero
//   sum [WIDTH]           p ^ carries
//   cout, ovf, zero       carry out, signed overflow (c[W]^c[W-1]), sum==0
module alu_carry_pipe #(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] p,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NGRP = WIDTH / GROUP;

   generate
      if (WIDTH % GROUP != 0) begin : g_param_chk
         $error("alu_carry_pipe: WIDTH must be a multiple of GROUP");
      end
   endgenerate

   // Everything S2 needs to finish the carry tree, captured together.
   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic             cin;
      logic [NGRP-1:0]  gg;
      logic [NGRP-1:0]  gp;
   } s1_t;

   s1_t             s1_q;
   logic            s1_vld;
   logic            s2_vld;
   logic            adv1;
   logic            adv2;
   logic [NGRP-1:0] gg_c;
   logic [NGRP-1:0] gp_c;
   logic [NGRP:0]   cg;
   logic [WIDTH:0]  c;
   logic [WIDTH-1:0] sum_d;

   // S2 may load when it is empty or its result leaves this cycle; S1 likewise behind S2.
   assign adv2      = !s2_vld || out_ready;
   assign adv1      = !s1_vld || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_vld;

   // Group generate/propagate. Walking the group from its low bit upward folds
   // "g[j] AND every p above j" into a running term.
   always_comb begin
      gg_c = '0;
      gp_c = '1;
      for (int k = 0; k < NGRP; k++) begin
         for (int j = 0; j < GROUP; j++) begin
            gg_c[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg_c[k]);
            gp_c[k] = gp_c[k] & p[k*GROUP+j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_q   <= '0;
      end else if (adv1) begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_q <= '{g: g, p: p, cin: cin, gg: gg_c, gp: gp_c};
         end
      end
   end

   // Group carries first, then each group ripples internally from its own
   // group carry-in, so no bit chain is longer than GROUP.
   always_comb begin
      cg    = '0;
      c     = '0;
      cg[0] = s1_q.cin;
      for (int k = 0; k < NGRP; k++) begin
         cg[k+1] = s1_q.gg[k] | (s1_q.gp[k] & cg[k]);
      end
      for (int k = 0; k < NGRP; k++) begin
         c[k*GROUP] = cg[k];
         for (int j = 0; j < GROUP; j++) begin
            c[k*GROUP+j+1] = s1_q.g[k*GROUP+j] | (s1_q.p[k*GROUP+j] & c[k*GROUP+j]);
         end
      end
      // Final carry comes from the lookahead tree rather than the last ripple.
      c[WIDTH] = cg[NGRP];
   end

   assign sum_d = s1_q.p ^ c[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_vld <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else if (adv2) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            sum  <= sum_d;
            cout <= c[WIDTH];
            ovf  <= c[WIDTH] ^ c[WIDTH-1];
            zero <= (sum_d == '0);
         end
      end
   end

endmodule
